// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order WriteBack stage and an out-of-order multiply/divide
//               unit. MD results are buffered in a 2-entry FIFO, pending MD
//               destinations are tracked in a busy mask, and a starvation
//               counter forces an MD write when WriteBack hogs the port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_result,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic [31:0] md_busy,
    output logic        wb_stall_req
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    // FIFO storage: entry 0 is always the head
    logic [1:0]  cnt_q,    cnt_d;
    logic [4:0]  e0_rd_q,  e0_rd_d;
    logic [31:0] e0_wd_q,  e0_wd_d;
    logic [4:0]  e1_rd_q,  e1_rd_d;
    logic [31:0] e1_wd_q,  e1_wd_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] busy_q,   busy_d;

    logic pw;
    logic head_valid;
    logic force_md;
    logic grant_head;
    logic push;

    assign pw         = RegWriteW && (RdW != 5'd0);
    // Head is ignored while in reset so no stale entry reaches the port
    assign head_valid = (cnt_q != 2'd0) && !rst;
    assign force_md   = head_valid && (starve_q == c_starve_limit);
    assign grant_head = force_md || (head_valid && !pw);

    assign md_ready     = (cnt_q != 2'd2) && !rst;
    // Accepted results aimed at x0 are consumed but never stored
    assign push         = md_valid && md_ready && (md_rd != 5'd0);
    assign wb_stall_req = force_md && pw;
    assign md_busy      = busy_q;

    // Write-port mux: forced/idle-port FIFO head, otherwise WriteBack
    always_comb begin
        rf_we = 1'b0;
        rf_rd = 5'd0;
        rf_wd = 32'd0;
        if (grant_head) begin
            rf_we = 1'b1;
            rf_rd = e0_rd_q;
            rf_wd = e0_wd_q;
        end else if (pw) begin
            rf_we = 1'b1;
            rf_rd = RdW;
            rf_wd = ResultW;
        end
    end

    // FIFO next state; push+pop only happens at count 1, where the new entry becomes head
    always_comb begin
        cnt_d   = cnt_q;
        e0_rd_d = e0_rd_q;
        e0_wd_d = e0_wd_q;
        e1_rd_d = e1_rd_q;
        e1_wd_d = e1_wd_q;
        if (grant_head && push) begin
            e0_rd_d = md_rd;
            e0_wd_d = md_result;
        end else if (grant_head) begin
            e0_rd_d = e1_rd_q;
            e0_wd_d = e1_wd_q;
            cnt_d   = cnt_q - 2'd1;
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                e0_rd_d = md_rd;
                e0_wd_d = md_result;
            end else begin
                e1_rd_d = md_rd;
                e1_wd_d = md_result;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Starvation counter: counts blocked head cycles, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (!head_valid || grant_head) begin
            starve_d = 4'd0;
        end else if (starve_q != c_starve_limit) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Busy mask: clear on head write, set on issue; set applied last so it wins
    always_comb begin
        busy_d = busy_q;
        if (grant_head) begin
            busy_d[e0_rd_q] = 1'b0;
        end
        if (md_issue && (md_issue_rd != 5'd0)) begin
            busy_d[md_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 2'd0;
            e0_rd_q  <= 5'd0;
            e0_wd_q  <= 32'd0;
            e1_rd_q  <= 5'd0;
            e1_wd_q  <= 32'd0;
            starve_q <= 4'd0;
            busy_q   <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            e0_rd_q  <= e0_rd_d;
            e0_wd_q  <= e0_wd_d;
            e1_rd_q  <= e1_rd_d;
            e1_wd_q  <= e1_wd_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter
//               (STARVE_LIMIT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [31:0] md_busy;
    logic        wb_stall_req;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteW    (RegWriteW),
        .RdW          (RdW),
        .ResultW      (ResultW),
        .md_issue     (md_issue),
        .md_issue_rd  (md_issue_rd),
        .md_valid     (md_valid),
        .md_rd        (md_rd),
        .md_result    (md_result),
        .md_ready     (md_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .md_busy      (md_busy),
        .wb_stall_req (wb_stall_req)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] wd, input logic stall);
        check({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
        if (we) begin
            check({tag, ".rd"}, {27'd0, rf_rd}, {27'd0, rd});
            check({tag, ".wd"}, rf_wd, wd);
        end
        check({tag, ".stall"}, {31'd0, wb_stall_req}, {31'd0, stall});
    endtask

    initial begin
        rst = 1'b1; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
        md_issue = 1'b0; md_issue_rd = 5'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_result = 32'd0;

        // ---------------- reset ----------------
        tick(); settle();
        check("rst.md_ready", {31'd0, md_ready}, 32'd0);
        tick(); rst = 1'b0; settle();
        check("rel.md_ready", {31'd0, md_ready}, 32'd1);
        check("rel.busy", md_busy, 32'd0);
        chk_port("rel", 1'b0, 5'd0, 32'd0, 1'b0);

        // ---------------- pipeline-only writes ----------------
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF; settle();
        chk_port("pw5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        RdW = 5'd0; settle();
        chk_port("pwx0", 1'b0, 5'd0, 32'd0, 1'b0);
        RegWriteW = 1'b0;

        // ---------------- single MD result on free port ----------------
        tick(); md_issue = 1'b1; md_issue_rd = 5'd7;
        tick(); md_issue = 1'b0; settle();
        check("iss7.busy", md_busy, 32'h0000_0080);
        md_valid = 1'b1; md_rd = 5'd7; md_result = 32'h12345678; settle();
        check("md7.ready", {31'd0, md_ready}, 32'd1);
        chk_port("md7.nobypass", 1'b0, 5'd0, 32'd0, 1'b0);
        tick(); md_valid = 1'b0; settle();
        chk_port("md7.write", 1'b1, 5'd7, 32'h12345678, 1'b0);
        check("md7.busy_held", md_busy, 32'h0000_0080);
        tick(); settle();
        check("md7.busy_clr", md_busy, 32'd0);
        chk_port("md7.idle", 1'b0, 5'd0, 32'd0, 1'b0);

        // ---------------- FIFO full + starvation ----------------
        md_issue = 1'b1; md_issue_rd = 5'd3;
        tick(); md_issue_rd = 5'd4;
        tick(); md_issue = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'hAAAA0000;
        md_valid = 1'b1; md_rd = 5'd3; md_result = 32'h33; settle();
        check("st.busy", md_busy, 32'h0000_0018);
        check("st.c1.ready", {31'd0, md_ready}, 32'd1);
        chk_port("st.c1", 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        tick(); md_rd = 5'd4; md_result = 32'h44; settle();
        check("st.c2.ready", {31'd0, md_ready}, 32'd1);
        chk_port("st.c2", 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        tick(); md_valid = 1'b0; settle();
        check("st.full.ready", {31'd0, md_ready}, 32'd0);
        chk_port("st.c3", 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        for (int i = 4; i <= 5; i++) begin
            tick(); settle();
            chk_port($sformatf("st.c%0d", i), 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        end
        tick(); settle();
        chk_port("st.force3", 1'b1, 5'd3, 32'h33, 1'b1);
        tick(); settle();
        chk_port("st.held_w", 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        check("st.busy3clr", md_busy, 32'h0000_0010);
        check("st.ready_again", {31'd0, md_ready}, 32'd1);
        for (int i = 8; i <= 10; i++) begin
            tick(); settle();
            chk_port($sformatf("st.c%0d", i), 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        end
        tick(); settle();
        chk_port("st.force4", 1'b1, 5'd4, 32'h44, 1'b1);
        tick(); settle();
        chk_port("st.held_w2", 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
        check("st.busy_empty", md_busy, 32'd0);
        RegWriteW = 1'b0; settle();
        chk_port("st.idle", 1'b0, 5'd0, 32'd0, 1'b0);

        // ---------------- reset mid-operation ----------------
        md_issue = 1'b1; md_issue_rd = 5'd3;
        tick(); md_issue_rd = 5'd4;
        tick(); md_issue = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd11; ResultW = 32'h0B0B0B0B;
        md_valid = 1'b1; md_rd = 5'd3; md_result = 32'h3333;
        tick(); md_rd = 5'd4; md_result = 32'h4444;
        tick(); md_valid = 1'b0; settle();
        check("rm.full", {31'd0, md_ready}, 32'd0);
        check("rm.busy", md_busy, 32'h0000_0018);
        RegWriteW = 1'b0; rst = 1'b1; settle();
        check("rm.rst.ready", {31'd0, md_ready}, 32'd0);
        chk_port("rm.rst", 1'b0, 5'd0, 32'd0, 1'b0);
        tick(); rst = 1'b0; settle();
        check("rm.rel.ready", {31'd0, md_ready}, 32'd1);
        check("rm.rel.busy", md_busy, 32'd0);
        chk_port("rm.rel", 1'b0, 5'd0, 32'd0, 1'b0);
        tick(); settle();
        chk_port("rm.rel2", 1'b0, 5'd0, 32'd0, 1'b0);

        // ---------------- simultaneous set/clear/drop ----------------
        md_issue = 1'b1; md_issue_rd = 5'd9;
        tick(); md_issue = 1'b0;
        md_valid = 1'b1; md_rd = 5'd9; md_result = 32'h99;
        tick(); md_rd = 5'd0; md_result = 32'h55; md_issue = 1'b1; md_issue_rd = 5'd9; settle();
        chk_port("sim.grant9", 1'b1, 5'd9, 32'h99, 1'b0);
        check("sim.ready", {31'd0, md_ready}, 32'd1);
        tick(); md_valid = 1'b0; md_issue = 1'b0; settle();
        check("sim.busy9", md_busy, 32'h0000_0200);
        chk_port("sim.dropped", 1'b0, 5'd0, 32'd0, 1'b0);
        check("sim.ready2", {31'd0, md_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
